util_tx_burst_ctrl: RTL and testbench

- Burst sequencer in the DAC clock domain, placed between the timestamp-gated stream output of the TX unpack path and the DAC data sink.
- Frames each burst:
  - asserts tx_enable a programmable pre-guard before the first block and holds it a post-guard after the last;
  - enforces burst length;
  - zero-fills gaps and ends the burst on an underflow timeout;
  - keeps saturating burst and underflow counters for status.

---
 rtl/util_tx_burst_ctrl_pkg.sv | 15 +
 rtl/util_tx_burst_sat_counter.sv | 22 ++
 rtl/util_tx_burst_ctrl.sv | 177 +++++++++++++++++
 tb/tb_util_tx_burst_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/util_tx_burst_ctrl_pkg.sv
// Shared types and default widths for the DAC-domain TX burst sequencer.
package util_tx_burst_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        STREAM,
        POST
    } burst_state_t;

    localparam int DEFAULT_DATA_WIDTH  = 64;
    localparam int DEFAULT_GUARD_WIDTH = 16;
    localparam int DEFAULT_COUNT_WIDTH = 32;

endpackage

// File: rtl/util_tx_burst_sat_counter.sv
// Saturating status counter; clear has priority over increment.
module util_tx_burst_sat_counter
    import util_tx_burst_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_COUNT_WIDTH
) (
    input  logic             dac_clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge dac_clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/util_tx_burst_ctrl.sv
// TX burst sequencer: guards tx_enable around each burst, enforces length and gap timeout.
// Optional abort input enabled by defining UTIL_TX_BURST_CTRL_ABORT_EN.
module util_tx_burst_ctrl
    import util_tx_burst_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int GUARD_WIDTH = DEFAULT_GUARD_WIDTH,
    parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
    input  logic                   dac_clk,
    input  logic                   reset,
    input  logic [COUNT_WIDTH-1:0] cfg_burst_len,
    input  logic [GUARD_WIDTH-1:0] cfg_pre_guard,
    input  logic [GUARD_WIDTH-1:0] cfg_post_guard,
    input  logic [GUARD_WIDTH-1:0] cfg_idle_timeout,
    input  logic                   status_clear,
`ifdef UTIL_TX_BURST_CTRL_ABORT_EN
    input  logic                   abort,
`endif
    input  logic                   s_axis_valid,
    output logic                   s_axis_ready,
    input  logic [DATA_WIDTH-1:0]  s_axis_data,
    output logic                   m_axis_valid,
    input  logic                   m_axis_ready,
    output logic [DATA_WIDTH-1:0]  m_axis_data,
    output logic                   tx_enable,
    output logic                   burst_active,
    output logic [COUNT_WIDTH-1:0] burst_count,
    output logic [COUNT_WIDTH-1:0] underflow_count
);

    burst_state_t           state;
    burst_state_t           state_next;

    logic [COUNT_WIDTH-1:0] burst_len_q;
    logic [GUARD_WIDTH-1:0] post_guard_q;
    logic [GUARD_WIDTH-1:0] idle_timeout_q;

    logic [GUARD_WIDTH-1:0] guard;
    logic [GUARD_WIDTH-1:0] gap;
    logic [GUARD_WIDTH-1:0] gap_inc;
    logic [COUNT_WIDTH-1:0] block_cnt;
    logic [COUNT_WIDTH-1:0] last_block;

    logic                   abort_req;
    logic                   xfer;
    logic                   gap_cycle;
    logic                   len_done;
    logic                   gap_done;

`ifdef UTIL_TX_BURST_CTRL_ABORT_EN
    assign abort_req = abort && ((state == PRE) || (state == STREAM));
`else
    assign abort_req = 1'b0;
`endif

    // Transfer and gap qualification; an abort cycle is neither.
    assign xfer       = s_axis_valid && s_axis_ready;
    assign gap_cycle  = (state == STREAM) && m_axis_ready && !s_axis_valid && !abort_req;
    assign gap_inc    = gap + 1'b1;
    assign last_block = burst_len_q - 1'b1;
    assign len_done   = xfer && (burst_len_q != '0) && (block_cnt == last_block);
    assign gap_done   = gap_cycle && (idle_timeout_q != '0) && (gap_inc == idle_timeout_q);

    always_ff @(posedge dac_clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (s_axis_valid) begin
                    state_next = (cfg_pre_guard == '0) ? STREAM : PRE;
                end
            end
            PRE: begin
                if (abort_req) begin
                    state_next = POST;
                end else if (guard <= 1) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (abort_req || len_done || gap_done) begin
                    state_next = POST;
                end
            end
            POST: begin
                if (guard <= 1) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        burst_active = (state == STREAM);
        m_axis_valid = (state != IDLE);
        s_axis_ready = (state == STREAM) && m_axis_ready && !abort_req;
        m_axis_data  = ((state == STREAM) && s_axis_valid) ? s_axis_data : '0;
    end

    // Config is captured once at burst start so host writes cannot disturb a burst in flight.
    always_ff @(posedge dac_clk) begin
        if (reset) begin
            tx_enable      <= 1'b0;
            guard          <= '0;
            gap            <= '0;
            block_cnt      <= '0;
            burst_len_q    <= '0;
            post_guard_q   <= '0;
            idle_timeout_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_axis_valid) begin
                        burst_len_q    <= cfg_burst_len;
                        post_guard_q   <= cfg_post_guard;
                        idle_timeout_q <= cfg_idle_timeout;
                        guard          <= cfg_pre_guard;
                        gap            <= '0;
                        block_cnt      <= '0;
                        tx_enable      <= 1'b1;
                    end
                end
                PRE: begin
                    guard <= (state_next == POST) ? post_guard_q : guard - 1'b1;
                end
                STREAM: begin
                    if (xfer) begin
                        block_cnt <= block_cnt + 1'b1;
                        gap       <= '0;
                    end else if (gap_cycle) begin
                        gap <= gap_inc;
                    end
                    if (state_next == POST) begin
                        guard <= post_guard_q;
                    end
                end
                POST: begin
                    guard <= guard - 1'b1;
                    if (guard <= 1) begin
                        tx_enable <= 1'b0;
                    end
                end
                default: tx_enable <= 1'b0;
            endcase
        end
    end

    util_tx_burst_sat_counter #(
        .WIDTH (COUNT_WIDTH)
    ) u_burst_counter (
        .dac_clk (dac_clk),
        .reset   (reset),
        .clear   (status_clear),
        .inc     (len_done),
        .count   (burst_count)
    );

    util_tx_burst_sat_counter #(
        .WIDTH (COUNT_WIDTH)
    ) u_underflow_counter (
        .dac_clk (dac_clk),
        .reset   (reset),
        .clear   (status_clear),
        .inc     (gap_done),
        .count   (underflow_count)
    );

endmodule

// File: tb/tb_util_tx_burst_ctrl.sv
// Randomized bench for util_tx_burst_ctrl against a burst-timeline reference model.
// Abort checks are compiled in when UTIL_TX_BURST_CTRL_ABORT_EN is defined.
module tb_util_tx_burst_ctrl;

    localparam int DW  = 32;
    localparam int GW  = 16;
    localparam int CW  = 5;
    localparam int SAT = (1 << CW) - 1;

    logic          dac_clk = 1'b0;
    logic          reset;
    logic [CW-1:0] cfg_burst_len;
    logic [GW-1:0] cfg_pre_guard;
    logic [GW-1:0] cfg_post_guard;
    logic [GW-1:0] cfg_idle_timeout;
    logic          status_clear;
`ifdef UTIL_TX_BURST_CTRL_ABORT_EN
    logic          abort;
`endif
    logic          s_axis_valid;
    logic          s_axis_ready;
    logic [DW-1:0] s_axis_data;
    logic          m_axis_valid;
    logic          m_axis_ready;
    logic [DW-1:0] m_axis_data;
    logic          tx_enable;
    logic          burst_active;
    logic [CW-1:0] burst_count;
    logic [CW-1:0] underflow_count;

    int check_count = 0;
    int pass_count  = 0;
    int mdl_bursts  = 0;
    int mdl_unders  = 0;

    util_tx_burst_ctrl #(
        .DATA_WIDTH  (DW),
        .GUARD_WIDTH (GW),
        .COUNT_WIDTH (CW)
    ) dut (
        .dac_clk          (dac_clk),
        .reset            (reset),
        .cfg_burst_len    (cfg_burst_len),
        .cfg_pre_guard    (cfg_pre_guard),
        .cfg_post_guard   (cfg_post_guard),
        .cfg_idle_timeout (cfg_idle_timeout),
        .status_clear     (status_clear),
`ifdef UTIL_TX_BURST_CTRL_ABORT_EN
        .abort            (abort),
`endif
        .s_axis_valid     (s_axis_valid),
        .s_axis_ready     (s_axis_ready),
        .s_axis_data      (s_axis_data),
        .m_axis_valid     (m_axis_valid),
        .m_axis_ready     (m_axis_ready),
        .m_axis_data      (m_axis_data),
        .tx_enable        (tx_enable),
        .burst_active     (burst_active),
        .burst_count      (burst_count),
        .underflow_count  (underflow_count)
    );

    always #5 dac_clk = ~dac_clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_count++;
        if (got === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge dac_clk);
        #1;
    endtask

    task automatic checkCounters(input string tag);
        @(negedge dac_clk);
        checkOutput({tag, "_burst_count"}, burst_count, mdl_bursts);
        checkOutput({tag, "_underflow_count"}, underflow_count, mdl_unders);
        nextCycle();
    endtask

    // One burst from IDLE back to IDLE. The model is a timeline: tx_enable rises the cycle
    // after valid is seen, streaming starts pre cycles later, ends on the len-th transfer or
    // tmo-th gap, and tx_enable trails for max(post,1) cycles.
    task automatic applyStimulus(input int pre, input int post, input int len, input int tmo,
                                 input int n_src, input int ready_pct, input int bubble_pct,
                                 input bit clr_at_end);
        logic [DW-1:0] blocks [$];
        int  xfers = 0;
        int  gaps  = 0;
        int  sent  = 0;
        int  end_c = 0;
        int  trail;
        int  begin_c;
        bit  ended = 1'b0;
        bit  done  = 1'b0;
        bit  in_stream;
        bit  exp_tx;
        bit  ends_now;
        bit  under_now;
        logic [DW-1:0] exp_data;

        for (int i = 0; i < n_src; i++) blocks.push_back(DW'($urandom));
        trail   = (post == 0) ? 1 : post;
        begin_c = 1 + pre;
        cfg_pre_guard    = GW'(pre);
        cfg_post_guard   = GW'(post);
        cfg_burst_len    = CW'(len);
        cfg_idle_timeout = GW'(tmo);

        for (int c = 0; !done; c++) begin
            if (c > 3000) begin
                checkOutput("burst_cycle_budget", 64'd0, 64'd1);
                break;
            end
            s_axis_valid = (c == 0) ||
                           (!ended && (sent < n_src) && ($urandom_range(99) >= bubble_pct));
            s_axis_data  = (s_axis_valid && sent < n_src) ? blocks[sent] : DW'($urandom);
            m_axis_ready = ($urandom_range(99) < ready_pct);

            in_stream = (c >= begin_c) && !ended;
            exp_tx    = (c >= 1) && (!ended || c <= end_c + trail);
            exp_data  = (in_stream && s_axis_valid) ? s_axis_data : '0;
            ends_now  = 1'b0;
            under_now = 1'b0;
            if (in_stream && m_axis_ready) begin
                if (s_axis_valid) begin
                    ends_now = (len != 0) && (xfers + 1 == len);
                end else begin
                    ends_now  = (tmo != 0) && (gaps + 1 == tmo);
                    under_now = ends_now;
                end
            end
            status_clear = clr_at_end && ends_now;

            @(negedge dac_clk);
            checkOutput("tx_enable", tx_enable, exp_tx);
            checkOutput("m_axis_valid", m_axis_valid, exp_tx);
            checkOutput("burst_active", burst_active, in_stream);
            checkOutput("s_axis_ready", s_axis_ready, in_stream && m_axis_ready);
            checkOutput("m_axis_data", m_axis_data, exp_data);

            if (in_stream && m_axis_ready) begin
                if (s_axis_valid) begin
                    xfers++;
                    sent++;
                    gaps = 0;
                end else begin
                    gaps++;
                end
            end
            if (ends_now) begin
                ended = 1'b1;
                end_c = c;
                if (status_clear) begin
                    mdl_bursts = 0;
                    mdl_unders = 0;
                end else if (under_now) begin
                    mdl_unders = (mdl_unders < SAT) ? mdl_unders + 1 : SAT;
                end else begin
                    mdl_bursts = (mdl_bursts < SAT) ? mdl_bursts + 1 : SAT;
                end
            end
            if (ended && c == end_c + trail + 1) done = 1'b1;
            nextCycle();
        end
        status_clear = 1'b0;
        s_axis_valid = 1'b0;
        checkCounters("end_of_burst");
    endtask

    initial begin
        int pre, post, len, tmo, n_src, rdy, bub;

        reset            = 1'b1;
        cfg_burst_len    = '0;
        cfg_pre_guard    = '0;
        cfg_post_guard   = '0;
        cfg_idle_timeout = '0;
        status_clear     = 1'b0;
`ifdef UTIL_TX_BURST_CTRL_ABORT_EN
        abort            = 1'b0;
`endif
        s_axis_valid     = 1'b1;
        s_axis_data      = 32'hDEAD_BEEF;
        m_axis_ready     = 1'b1;
        repeat (3) nextCycle();

        @(negedge dac_clk);
        checkOutput("reset_tx_enable", tx_enable, 1'b0);
        checkOutput("reset_m_axis_valid", m_axis_valid, 1'b0);
        checkOutput("reset_s_axis_ready", s_axis_ready, 1'b0);
        checkOutput("reset_burst_active", burst_active, 1'b0);
        checkOutput("reset_m_axis_data", m_axis_data, 64'd0);
        checkOutput("reset_burst_count", burst_count, 64'd0);
        checkOutput("reset_underflow_count", underflow_count, 64'd0);
        nextCycle();
        s_axis_valid = 1'b0;
        reset        = 1'b0;
        nextCycle();

        // Reset mid-burst after two blocks: IDLE next cycle, no post-guard, counters untouched.
        cfg_pre_guard  = 16'd1;
        cfg_post_guard = 16'd3;
        cfg_burst_len  = 5'd8;
        s_axis_valid   = 1'b1;
        nextCycle();
        nextCycle();
        for (int i = 0; i < 2; i++) begin
            s_axis_data = DW'($urandom);
            @(negedge dac_clk);
            checkOutput("midreset_stream_ready", s_axis_ready, 1'b1);
            checkOutput("midreset_stream_data", m_axis_data, s_axis_data);
            nextCycle();
        end
        reset = 1'b1;
        nextCycle();
        reset        = 1'b0;
        s_axis_valid = 1'b0;
        @(negedge dac_clk);
        checkOutput("midreset_tx_enable", tx_enable, 1'b0);
        checkOutput("midreset_burst_active", burst_active, 1'b0);
        checkOutput("midreset_m_axis_valid", m_axis_valid, 1'b0);
        nextCycle();
        checkCounters("midreset");

`ifdef UTIL_TX_BURST_CTRL_ABORT_EN
        // Abort during PRE: two post-guard cycles then IDLE, no counter change.
        cfg_pre_guard    = 16'd4;
        cfg_post_guard   = 16'd2;
        cfg_burst_len    = 5'd0;
        cfg_idle_timeout = 16'd0;
        s_axis_valid     = 1'b1;
        nextCycle();
        @(negedge dac_clk);
        checkOutput("abort_pre_tx_enable", tx_enable, 1'b1);
        nextCycle();
        abort        = 1'b1;
        s_axis_valid = 1'b0;
        nextCycle();
        abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge dac_clk);
            checkOutput("abort_post_tx_enable", tx_enable, i < 2);
            checkOutput("abort_post_burst_active", burst_active, 1'b0);
            nextCycle();
        end
        checkCounters("abort");
`endif

        // Directed bursts: length-terminated, timeout-terminated, ready throttled.
        applyStimulus(3, 2, 4, 0, 4, 100, 0, 1'b0);
        applyStimulus(0, 1, 0, 5, 10, 100, 0, 1'b0);
        applyStimulus(2, 0, 8, 2, 8, 50, 0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            pre  = $urandom_range(5);
            post = $urandom_range(4);
            rdy  = $urandom_range(100, 30);
            bub  = $urandom_range(25);
            if ($urandom_range(1) == 0) begin
                len   = $urandom_range(12, 1);
                n_src = len;
                tmo   = $urandom_range(4);
                if (tmo == 0) bub = 0;
            end else begin
                n_src = $urandom_range(10, 1);
                tmo   = $urandom_range(6, 1);
                len   = ($urandom_range(1) == 0) ? 0 : n_src + $urandom_range(5, 1);
            end
            applyStimulus(pre, post, len, tmo, n_src, rdy, bub, 1'b0);
        end

        // Drive underflow_count into saturation, then clear it in a completion cycle.
        for (int k = 0; k < SAT + 2; k++) applyStimulus(0, 0, 0, 1, 1, 100, 0, 1'b0);
        applyStimulus(0, 0, 0, 1, 1, 100, 0, 1'b1);
        for (int k = 0; k < SAT + 1; k++) applyStimulus(1, 0, 0, 1, 1, 100, 0, 1'b0);
        checkOutput("underflow_saturated", underflow_count, SAT);

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
